// File: rtl/tohost_monitor.sv
// End-of-test monitor: snoops the store bus for a pass/fail signature, drains,
// then reports the result, cycle count and end code, and requests memory dumps.
module tohost_monitor #(
  parameter int unsigned                 ADDR_WIDTH     = 32,
  parameter int unsigned                 DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0]       PASS_VALUE     = 32'hdeadbeef,
  parameter logic [DATA_WIDTH-1:0]       FAIL_VALUE     = 32'hbadc0de0,
  parameter bit                          ADDR_MATCH_EN  = 1'b0,
  parameter logic [ADDR_WIDTH-1:0]       TOHOST_ADDR    = 32'h0000_0ffc,
  parameter int unsigned                 DRAIN_CYCLES   = 5,
  parameter int unsigned                 TIMEOUT_CYCLES = 100000,
  parameter int unsigned                 DUMP_INTERVAL  = 100,
  parameter int unsigned                 CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dmem_write,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [DATA_WIDTH-1:0]   end_code,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic                    dump_req
);

  // Counter widths are floored at one bit so a zero parameter still elaborates.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned IVL_W   = (DUMP_INTERVAL > 0) ? $clog2(DUMP_INTERVAL + 1) : 1;

  localparam logic [DRAIN_W-1:0]   DRAIN_LAST  =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IVL_W-1:0]     IVL_PERIOD  = IVL_W'(DUMP_INTERVAL);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL,
    RES_TIMEOUT
  } result_e;

  state_e               state;
  result_e              kind;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [IVL_W-1:0]     ivl_cnt;

  logic                 hit;
  logic                 pass_hit;
  logic                 fail_hit;
  logic                 cnt_inc;
  logic                 cnt_timeout;
  logic                 ivl_wrap;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [IVL_W-1:0]     ivl_next;
  result_e              term_kind;
  result_e              done_kind;
  logic                 enter_done;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit         = dmem_write && (&dmem_wstrb) &&
                  (!ADDR_MATCH_EN || (dmem_addr == TOHOST_ADDR));
    pass_hit    = hit && (dmem_wdata == PASS_VALUE);
    fail_hit    = hit && (dmem_wdata == FAIL_VALUE) && !pass_hit;

    cnt_inc     = (cycle_count != CNT_MAX);
    cnt_next    = cnt_inc ? cycle_count + 1'b1 : cycle_count;
    cnt_timeout = cnt_inc && (TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_VAL);

    ivl_next    = ivl_cnt + 1'b1;
    ivl_wrap    = (DUMP_INTERVAL != 0) && cnt_inc && (ivl_next == IVL_PERIOD);

    // A signature hit outranks a timeout landing on the same edge.
    term_kind = RES_NONE;
    if (pass_hit)         term_kind = RES_PASS;
    else if (fail_hit)    term_kind = RES_FAIL;
    else if (cnt_timeout) term_kind = RES_TIMEOUT;

    done_kind  = (state == ST_RUN) ? term_kind : kind;
    enter_done = ((state == ST_RUN) && (term_kind != RES_NONE) && (DRAIN_CYCLES == 0)) ||
                 ((state == ST_DRAIN) && (drain_cnt == DRAIN_LAST));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      kind        <= RES_NONE;
      drain_cnt   <= '0;
      ivl_cnt     <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      end_code    <= '0;
      cycle_count <= '0;
      dump_req    <= 1'b0;
    end else begin
      dump_req <= 1'b0;

      case (state)
        ST_RUN: begin
          if (pass_hit || fail_hit) begin
            // The terminating store is not counted as a run cycle.
            kind     <= term_kind;
            end_code <= dmem_wdata;
            if (DRAIN_CYCLES != 0) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            cycle_count <= cnt_next;
            if (cnt_inc && (DUMP_INTERVAL != 0)) begin
              ivl_cnt <= ivl_wrap ? '0 : ivl_next;
            end
            if (ivl_wrap) begin
              dump_req <= 1'b1;
            end
            if (cnt_timeout) begin
              kind     <= RES_TIMEOUT;
              end_code <= '0;
              if (DRAIN_CYCLES != 0) begin
                state     <= ST_DRAIN;
                drain_cnt <= '0;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (drain_cnt != DRAIN_LAST) begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        ST_DONE: begin
        end

        default: state <= ST_RUN;
      endcase

      // Result flags, done and the final dump pulse all rise on one edge; a
      // coinciding periodic pulse merges into the same single-cycle pulse.
      if (enter_done) begin
        state    <= ST_DONE;
        done     <= 1'b1;
        pass     <= (done_kind == RES_PASS);
        fail     <= (done_kind == RES_FAIL);
        timeout  <= (done_kind == RES_TIMEOUT);
        dump_req <= 1'b1;
      end
    end
  end

endmodule
